opb_register_bank_ppc2simulink: RTL

Parametrised bank of PowerPC-writable software registers on the OPB, presenting C_NUM_REGS 32-bit words to Simulink user logic in the OPB clock domain. Writes land in per-register shadow words and are committed atomically through a control word, or pass straight through for registers flagged direct. It replaces one-instance-per-register wrappers in the XPS_ROACH base with a single slave per register group. It adds byte-enable writes, readback and per-register update strobes.

---
 rtl/opb_regbank_ack_fsm.sv | 5 +
 rtl/opb_regbank_pkg.sv | 56 +++++
 rtl/opb_register_bank_ppc2simulink_ack.sv | 49 ++++
 rtl/opb_register_bank_ppc2simulink.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/opb_regbank_ack_fsm.sv
// Reserved file; the ACK FSM is defined in
// opb_register_bank_ppc2simulink_ack.sv.
package opb_regbank_ack_fsm_unused_pkg;
  localparam int UNUSED_MARK = 0;
endpackage

// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB software register bank.
// Word values are numeric: OPB bit 0 is the MSB, byte enable 0 is bits 31:24.
package opb_regbank_pkg;

  localparam int DW = 32;

  // Control word fields in LSB-0 numbering (commit flag is OPB bit 31)
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_COUNT_LSB  = 24;

  typedef enum logic {
    IDLE,
    ACK
  } ack_state_t;

  typedef enum logic [1:0] {
    REG_DATA,
    REG_CTRL,
    REG_NONE
  } region_t;

  function automatic logic [31:0] word_offset(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return (addr - base) >> 2;
  endfunction

  function automatic region_t decode_region(
    input logic [31:0] off,
    input logic [31:0] nregs
  );
    region_t r;
    if (off < nregs)
      r = REG_DATA;
    else if (off == nregs)
      r = REG_CTRL;
    else
      r = REG_NONE;
    return r;
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int j = 0; j < 4; j++)
      if (be[j])
        r[8*j +: 8] = new_w[8*j +: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_ack.sv
// OPB slave handshake: address hit, IDLE/ACK FSM, registered xferAck.
// start marks the single cycle in which the register file performs the access.
module opb_slave_ack_fsm
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h0108F100,
  parameter logic [31:0] C_HIGHADDR = 32'h0108F1FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        select,
  input  logic [31:0] addr,
  output logic        start,
  output logic        xfer_ack
);

  ack_state_t state;
  logic       hit;

  assign hit   = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign start = (state == IDLE) && hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      xfer_ack <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            state    <= ACK;
            xfer_ack <= 1'b1;
          end else begin
            xfer_ack <= 1'b0;
          end
        end
        ACK: begin
          state    <= IDLE;
          xfer_ack <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          xfer_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// PPC-writable register bank: shadow words committed atomically via a
// control word, or written straight through for direct registers.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0108F100,
  parameter logic [31:0] C_HIGHADDR    = 32'h0108F1FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter string       C_FAMILY      = "virtex5",
  parameter int          C_NUM_REGS    = 4,
  parameter logic [63:0] C_DIRECT_MASK = 64'h0,
  parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]    user_data_valid
);

  localparam int IW = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
  localparam logic [C_NUM_REGS-1:0] DIRECT =
    C_DIRECT_MASK[C_NUM_REGS-1:0];
  localparam logic [31:0] NREGS = 32'(C_NUM_REGS);
  localparam logic [7:0]  NREG8 = 8'(C_NUM_REGS);
  localparam bit FAMILY_IS_V5_unused = (C_FAMILY == "virtex5");

  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] off;
  logic [IW-1:0] idx;
  region_t     region;
  logic        start;
  logic        is_data;
  logic        is_ctrl;
  logic [31:0] merged;
  logic [31:0] ctrl_word;
  logic [31:0] rdata;

  logic [31:0] shadow [C_NUM_REGS];
  logic [31:0] outw   [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] dirty;

  logic unused_inputs;
  assign unused_inputs = OPB_seqAddr ^ (^off);

  assign addr   = 32'(OPB_ABus);
  assign wdata  = 32'(OPB_DBus);
  assign be     = OPB_BE;
  assign off    = word_offset(addr, C_BASEADDR);
  assign idx    = off[IW-1:0];
  assign region = decode_region(off, NREGS);

  assign is_data = (region == REG_DATA);
  assign is_ctrl = (region == REG_CTRL);
  assign merged  = be_merge(shadow[idx], wdata, be);

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_COUNT_LSB +: 8] = NREG8;
    ctrl_word[CTRL_COMMIT_BIT]     = |dirty;
  end

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_ack (
    .clk      (OPB_Clk),
    .rst_n    (OPB_Rst_n),
    .select   (OPB_select),
    .addr     (addr),
    .start    (start),
    .xfer_ack (Sl_xferAck)
  );

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        shadow[i] <= C_RESET_VALUE;
        outw[i]   <= C_RESET_VALUE;
      end
      dirty           <= '0;
      user_data_valid <= '0;
      rdata           <= '0;
    end else begin
      user_data_valid <= '0;
      rdata           <= '0;
      if (start) begin
        unique case (1'b1)
          is_data && !OPB_RNW: begin
            if (|be) begin
              shadow[idx] <= merged;
              if (DIRECT[idx]) begin
                outw[idx]            <= merged;
                user_data_valid[idx] <= 1'b1;
              end else begin
                dirty[idx] <= 1'b1;
              end
            end
          end
          is_data && OPB_RNW: begin
            rdata <= DIRECT[idx] ? outw[idx] : shadow[idx];
          end
          is_ctrl && !OPB_RNW: begin
            // Only BE[3] covers the commit flag byte
            if (be[0] && wdata[CTRL_COMMIT_BIT]) begin
              for (int i = 0; i < C_NUM_REGS; i++)
                if (!DIRECT[i])
                  outw[i] <= shadow[i];
              user_data_valid <= dirty;
              dirty           <= '0;
            end
          end
          is_ctrl && OPB_RNW: begin
            rdata <= ctrl_word;
          end
          default: begin
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = outw[g];
  end

  assign Sl_DBus    = rdata;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule
